fb_write_arbiter: RTL and testbench

Shares the single VGA frame-buffer index-memory write port among three sources: processor stores, a PS/2-driven brush requester, and a built-in full-screen clear engine. It sits between `processor` / brush logic and `vga_controller` and drives the controller's index write address, data and write-enable. The processor cannot be stalled, so its writes pass through a small FIFO. Brush and FIFO traffic are served round-robin, and a clear owns the port exclusively until it finishes.

---
 rtl/fb_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: processor store FIFO and brush requester share the
// port round-robin; a full-screen clear engine takes the port exclusively while running.
module fb_write_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8,
   parameter int FB_DEPTH   = 307200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_data,
   input  logic              brush_valid,
   output logic              brush_ready,
   input  logic [ADDR_W-1:0] brush_addr,
   input  logic [DATA_W-1:0] brush_data,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              cpu_overflow,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   typedef enum logic {ARB, CLEAR} state_t;
   typedef enum logic {SRC_BRUSH, SRC_CPU} src_t;

   state_t            state, state_nx;
   src_t              last_grant, last_grant_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic              clr_last, clr_last_nx;
   logic [DATA_W-1:0] color, color_nx;
   logic              fb_we_nx, clr_done_nx;
   logic [ADDR_W-1:0] fb_addr_nx;
   logic [DATA_W-1:0] fb_data_nx;

   logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] q_data [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              fifo_empty, fifo_full, cpu_ok, push, pop;
   logic              cpu_gnt, brush_gnt, brush_ok;
   logic              unused_hi;

   assign unused_hi  = ^cpu_data[31:DATA_W];
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign cpu_ok     = cpu_we && (cpu_addr[31:ADDR_W] == '0) && (cpu_addr < 32'(FB_DEPTH));
   assign brush_ok   = 32'(brush_addr) < 32'(FB_DEPTH);

   // Both pending: serve the source opposite the previous grant.
   assign brush_ready = !reset && (state == ARB) && !clr_start &&
                        (fifo_empty || last_grant == SRC_CPU);
   assign brush_gnt   = brush_valid && brush_ready;
   assign cpu_gnt     = (state == ARB) && !clr_start && !fifo_empty &&
                        !(brush_valid && last_grant == SRC_CPU);
   assign pop         = cpu_gnt;
   // A full FIFO still takes a push when the same edge pops.
   assign push        = cpu_ok && (!fifo_full || pop);
   assign clr_busy    = (state == CLEAR);

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      cnt_nx        = cnt;
      clr_last_nx   = clr_last;
      color_nx      = color;
      fb_we_nx      = 1'b0;
      fb_addr_nx    = fb_addr;
      fb_data_nx    = fb_data;
      clr_done_nx   = 1'b0;
      case (state)
         ARB: begin
            if (clr_start) begin
               state_nx    = CLEAR;
               cnt_nx      = '0;
               clr_last_nx = 1'b0;
               color_nx    = clr_color;
            end else if (cpu_gnt) begin
               last_grant_nx = SRC_CPU;
               fb_we_nx      = 1'b1;
               fb_addr_nx    = q_addr[rd_ptr];
               fb_data_nx    = q_data[rd_ptr];
            end else if (brush_gnt) begin
               last_grant_nx = SRC_BRUSH;
               if (brush_ok) begin
                  fb_we_nx   = 1'b1;
                  fb_addr_nx = brush_addr;
                  fb_data_nx = brush_data;
               end
            end
         end
         CLEAR: begin
            // One idle cycle after the last write so busy covers it and done follows.
            if (clr_last) begin
               state_nx    = ARB;
               clr_last_nx = 1'b0;
               cnt_nx      = '0;
               clr_done_nx = 1'b1;
            end else begin
               fb_we_nx   = 1'b1;
               fb_addr_nx = cnt;
               fb_data_nx = color;
               if (cnt == LAST_ADDR) clr_last_nx = 1'b1;
               else                  cnt_nx      = cnt + 1'b1;
            end
         end
         default: state_nx = ARB;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ARB;
         last_grant <= SRC_BRUSH;
         cnt        <= '0;
         clr_last   <= 1'b0;
         color      <= '0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         clr_done   <= 1'b0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         cnt        <= cnt_nx;
         clr_last   <= clr_last_nx;
         color      <= color_nx;
         fb_we      <= fb_we_nx;
         fb_addr    <= fb_addr_nx;
         fb_data    <= fb_data_nx;
         clr_done   <= clr_done_nx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         cpu_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (cpu_ok && !push) cpu_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_addr[wr_ptr] <= cpu_addr[ADDR_W-1:0];
         q_data[wr_ptr] <= cpu_data[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a full-size instance plus a 16-pixel instance
// so clear completion can be observed in a few cycles. Inputs change on the falling edge.
module tb_fb_write_arbiter;

   logic        clock, reset;
   logic        cpu_we;
   logic [31:0] cpu_addr, cpu_data;
   logic        brush_valid;
   logic [18:0] brush_addr;
   logic [7:0]  brush_data;
   logic        clr_start;
   logic [7:0]  clr_color;

   logic        a_brush_ready, a_clr_busy, a_clr_done, a_cpu_overflow, a_fb_we;
   logic [18:0] a_fb_addr;
   logic [7:0]  a_fb_data;
   logic        b_brush_ready, b_clr_busy, b_clr_done, b_cpu_overflow, b_fb_we;
   logic [18:0] b_fb_addr;
   logic [7:0]  b_fb_data;

   int checks = 0;
   int failures = 0;

   fb_write_arbiter dut (
      .clock(clock), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .brush_valid(brush_valid), .brush_ready(a_brush_ready), .brush_addr(brush_addr),
      .brush_data(brush_data), .clr_start(clr_start), .clr_color(clr_color),
      .clr_busy(a_clr_busy), .clr_done(a_clr_done), .cpu_overflow(a_cpu_overflow),
      .fb_we(a_fb_we), .fb_addr(a_fb_addr), .fb_data(a_fb_data));

   fb_write_arbiter #(.FB_DEPTH(16)) dut16 (
      .clock(clock), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .brush_valid(brush_valid), .brush_ready(b_brush_ready), .brush_addr(brush_addr),
      .brush_data(brush_data), .clr_start(clr_start), .clr_color(clr_color),
      .clr_busy(b_clr_busy), .clr_done(b_clr_done), .cpu_overflow(b_cpu_overflow),
      .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_data(b_fb_data));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1; cpu_we = 1'b0; brush_valid = 1'b0; clr_start = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int bad_we, bad_done, bad_busy;
      reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0; brush_valid = 1'b0;
      brush_addr = '0; brush_data = '0; clr_start = 1'b0; clr_color = '0;
      step(); step();
      checks++; if ({a_fb_we, a_clr_busy, a_clr_done, a_cpu_overflow} !== 4'b0)
         begin failures++; $display("FAIL reset_flags got=%b exp=0000", {a_fb_we, a_clr_busy, a_clr_done, a_cpu_overflow}); end
      checks++; if ({a_fb_addr, a_fb_data} !== 27'd0)
         begin failures++; $display("FAIL reset_bus got=%0h/%0h exp=0/0", a_fb_addr, a_fb_data); end
      reset = 1'b0;
      step(); clr_start = 1'b1; clr_color = 8'h77;
      step(); clr_start = 1'b0; cpu_we = 1'b1; cpu_addr = 32'd500; cpu_data = 32'h50;
      step(); cpu_addr = 32'd501;
      checks++; if (a_clr_busy !== 1'b1)
         begin failures++; $display("FAIL reset_busy_pre got=%b exp=1", a_clr_busy); end
      step(); cpu_we = 1'b0;
      repeat (99) step();
      checks++; if (a_fb_we !== 1'b1 || a_fb_addr !== 19'd100 || a_fb_data !== 8'h77)
         begin failures++; $display("FAIL reset_midclear got=%b/%0d/%0h exp=1/100/77", a_fb_we, a_fb_addr, a_fb_data); end
      reset = 1'b1;
      step();
      checks++; if ({a_fb_we, a_clr_busy, a_clr_done, a_cpu_overflow, a_brush_ready} !== 5'b0)
         begin failures++; $display("FAIL reset_abort_flags got=%b exp=00000", {a_fb_we, a_clr_busy, a_clr_done, a_cpu_overflow, a_brush_ready}); end
      checks++; if ({a_fb_addr, a_fb_data} !== 27'd0)
         begin failures++; $display("FAIL reset_abort_bus got=%0h/%0h exp=0/0", a_fb_addr, a_fb_data); end
      step(); reset = 1'b0;
      bad_we = 0; bad_done = 0; bad_busy = 0;
      repeat (30) begin
         step();
         if (a_fb_we)    bad_we++;
         if (a_clr_done) bad_done++;
         if (a_clr_busy) bad_busy++;
      end
      checks++; if (bad_we != 0)   begin failures++; $display("FAIL reset_no_write got=%0d exp=0", bad_we); end
      checks++; if (bad_done != 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", bad_done); end
      checks++; if (bad_busy != 0) begin failures++; $display("FAIL reset_no_busy got=%0d exp=0", bad_busy); end
   endtask

   task automatic test_cpu_path();
      int bad_we;
      do_reset();
      step(); cpu_we = 1'b1; cpu_addr = 32'h12345; cpu_data = 32'hFFFF_FF3C;
      step(); cpu_we = 1'b0;
      checks++; if (a_fb_we !== 1'b0) begin failures++; $display("FAIL cpu_lat1 got=%b exp=0", a_fb_we); end
      step();
      checks++; if (a_fb_we !== 1'b1 || a_fb_addr !== 19'h12345 || a_fb_data !== 8'h3C)
         begin failures++; $display("FAIL cpu_write got=%b/%0h/%0h exp=1/12345/3c", a_fb_we, a_fb_addr, a_fb_data); end
      step();
      checks++; if (a_fb_we !== 1'b0 || a_fb_addr !== 19'h12345 || a_fb_data !== 8'h3C)
         begin failures++; $display("FAIL cpu_hold got=%b/%0h/%0h exp=0/12345/3c", a_fb_we, a_fb_addr, a_fb_data); end
      cpu_we = 1'b1; cpu_addr = 32'd307200; cpu_data = 32'h99;
      step(); cpu_addr = 32'h8000_0005;
      step(); cpu_addr = 32'd307199; cpu_data = 32'h42;
      step(); cpu_we = 1'b0;
      bad_we = 0;
      repeat (4) begin
         step();
         if (a_fb_we && a_fb_addr != 19'd307199) bad_we++;
      end
      checks++; if (bad_we != 0) begin failures++; $display("FAIL cpu_discard got=%0d exp=0", bad_we); end
      checks++; if (a_cpu_overflow !== 1'b0) begin failures++; $display("FAIL cpu_discard_ovf got=%b exp=0", a_cpu_overflow); end
      checks++; if (a_fb_addr !== 19'd307199 || a_fb_data !== 8'h42)
         begin failures++; $display("FAIL cpu_last_addr got=%0d/%0h exp=307199/42", a_fb_addr, a_fb_data); end
   endtask

   task automatic test_contention();
      int exp_seq[9] = '{1000, 10, 1001, 11, 1002, 12, 1003, 13, 14};
      logic [18:0] got[$];
      logic hs;
      do_reset();
      brush_addr = 19'd10; brush_data = 8'd10;
      step(); cpu_we = 1'b1; cpu_addr = 32'd1000; cpu_data = 32'hC0; brush_valid = 1'b0; hs = 1'b0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (hs) begin brush_addr = brush_addr + 1'b1; brush_data = brush_addr[7:0]; end
         if (a_fb_we) got.push_back(a_fb_addr);
         cpu_we = (i < 3); cpu_addr = 32'(1001 + i); cpu_data = 32'(8'hC1 + i);
         brush_valid = 1'b1;
         #1 hs = brush_valid && a_brush_ready;
      end
      brush_valid = 1'b0; cpu_we = 1'b0;
      checks++; if (got.size() < 9) begin failures++; $display("FAIL rr_count got=%0d exp>=9", got.size()); end
      for (int i = 0; i < 9 && i < got.size(); i++) begin
         checks++; if (got[i] !== 19'(exp_seq[i]))
            begin failures++; $display("FAIL rr_seq[%0d] got=%0d exp=%0d", i, got[i], exp_seq[i]); end
      end
      checks++; if (a_cpu_overflow !== 1'b0) begin failures++; $display("FAIL rr_overflow got=%b exp=0", a_cpu_overflow); end
   endtask

   task automatic test_overflow();
      do_reset();
      step(); clr_start = 1'b1; clr_color = 8'h05;
      for (int c = 1; c <= 26; c++) begin
         step();
         clr_start = 1'b0;
         cpu_we = (c <= 6); cpu_addr = 32'(c); cpu_data = 32'(16 + c);
         if (c == 5) begin
            checks++; if (b_cpu_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", b_cpu_overflow); end
         end
         if (c == 7 || c == 26) begin
            checks++; if (b_cpu_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set c=%0d got=%b exp=1", c, b_cpu_overflow); end
         end
         if (c >= 2 && c <= 17) begin
            checks++; if (b_fb_we !== 1'b1 || b_fb_addr !== 19'(c - 2) || b_fb_data !== 8'h05)
               begin failures++; $display("FAIL ovf_clear c=%0d got=%b/%0d/%0h exp=1/%0d/05", c, b_fb_we, b_fb_addr, b_fb_data, c - 2); end
         end
         if (c == 18) begin
            checks++; if (b_clr_done !== 1'b1) begin failures++; $display("FAIL ovf_done got=%b exp=1", b_clr_done); end
         end
         if (c >= 19 && c <= 22) begin
            checks++; if (b_fb_we !== 1'b1 || b_fb_addr !== 19'(c - 18) || b_fb_data !== 8'(16 + c - 18))
               begin failures++; $display("FAIL ovf_drain c=%0d got=%b/%0d/%0h exp=1/%0d/%0h", c, b_fb_we, b_fb_addr, b_fb_data, c - 18, 16 + c - 18); end
         end
         if (c >= 23) begin
            checks++; if (b_fb_we !== 1'b0) begin failures++; $display("FAIL ovf_dropped c=%0d got=%b exp=0", c, b_fb_we); end
         end
      end
      cpu_we = 1'b0;
   endtask

   task automatic test_clear();
      logic exp_we;
      do_reset();
      step(); clr_start = 1'b1; clr_color = 8'hAA;
      for (int c = 1; c <= 20; c++) begin
         step();
         clr_start = (c == 2); clr_color = (c == 2) ? 8'h33 : 8'h00;
         exp_we = (c >= 2 && c <= 17);
         checks++; if (b_fb_we !== exp_we) begin failures++; $display("FAIL clr_we c=%0d got=%b exp=%b", c, b_fb_we, exp_we); end
         if (exp_we) begin
            checks++; if (b_fb_addr !== 19'(c - 2) || b_fb_data !== 8'hAA)
               begin failures++; $display("FAIL clr_px c=%0d got=%0d/%0h exp=%0d/aa", c, b_fb_addr, b_fb_data, c - 2); end
         end
         checks++; if (b_clr_busy !== (c <= 17)) begin failures++; $display("FAIL clr_busy c=%0d got=%b exp=%b", c, b_clr_busy, c <= 17); end
         checks++; if (b_clr_done !== (c == 18)) begin failures++; $display("FAIL clr_done c=%0d got=%b exp=%b", c, b_clr_done, c == 18); end
         if (c <= 17) begin
            checks++; if (b_brush_ready !== 1'b0) begin failures++; $display("FAIL clr_ready c=%0d got=%b exp=0", c, b_brush_ready); end
         end
      end
      clr_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_cpu_path();
      test_contention();
      test_overflow();
      test_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
